// File: rtl/vin_sweep_gen.sv
// -----------------------------------------------------------------------------
// vin_sweep_gen
//
// Purpose:
//   Synthesizable stimulus source for memristor_conductance.  Produces a
//   repeatable bipolar triangle on the signed vin bus:
//     0 -> +VPEAK -> 0 -> -VPEAK -> 0
//   The sweep is repeated NSWEEP times per start request.  Each vin value is
//   held for DWELL cycles.  sample_valid marks the last cycle of each hold, so
//   downstream conductance capture samples only a settled input.
//
// Parameters:
//   VW      vin width in bits, two's complement
//   VPEAK   sweep amplitude in vin LSBs (1 .. 2^(VW-1)-1)
//   STEP    vin increment per step (1 .. VPEAK)
//   DWELL   cycles each vin value is held (>= 1)
//   NSWEEP  full triangle periods per start (>= 1)
//
// Ports:
//   clk           in   system clock, rising edge
//   reset         in   synchronous, active-high; clears all state
//   start         in   run request, honoured only in IDLE
//   abort         in   synchronous run cancel, effective in any RUN state
//   vin           out  signed sweep voltage
//   phase         out  0 rise to +peak, 1 fall to 0, 2 fall to -peak,
//                      3 rise to 0; 0 when not running
//   sample_valid  out  high on the last dwell cycle of each vin value
//   busy          out  high while a run is active
//   done          out  one-cycle pulse on normal completion
//   sweep_idx     out  0-based index of the current sweep, saturates at 255
// -----------------------------------------------------------------------------
module vin_sweep_gen #(
    parameter int VW     = 8,
    parameter int VPEAK  = 4,
    parameter int STEP   = 1,
    parameter int DWELL  = 1,
    parameter int NSWEEP = 1
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 start,
    input  logic                 abort,
    output logic signed [VW-1:0] vin,
    output logic [1:0]           phase,
    output logic                 sample_valid,
    output logic                 busy,
    output logic                 done,
    output logic [7:0]           sweep_idx
);

    typedef enum logic [2:0] {
        IDLE,
        RUN_P_UP,
        RUN_P_DN,
        RUN_N_DN,
        RUN_N_UP,
        FINISH
    } state_t;

    // Dwell counter just wide enough to reach DWELL-1.
    localparam int DW = (DWELL > 1) ? $clog2(DWELL) : 1;
    localparam logic [DW-1:0] DWELL_LAST = DW'(DWELL - 1);

    // With DWELL == 1 every value is its own last dwell cycle, so the first
    // cycle of a new value is already a sample cycle.
    localparam logic SV_FIRST = (DWELL == 1);

    // All sweep arithmetic runs one bit wider than vin so that neither the
    // step past a peak nor the step below -VPEAK can wrap before clamping.
    localparam logic signed [VW:0] ZERO_W     = '0;
    localparam logic signed [VW:0] PEAK_W     = (VW+1)'(VPEAK);
    localparam logic signed [VW:0] STEP_W     = (VW+1)'(STEP);
    localparam logic signed [VW:0] NEG_PEAK_W = -PEAK_W;
    localparam logic signed [VW:0] NEG_STEP_W = -STEP_W;

    // First value of each segment, clamped at that segment's target.
    localparam logic signed [VW:0] PDN_ENTRY =
        ((PEAK_W - STEP_W) < ZERO_W) ? ZERO_W : (PEAK_W - STEP_W);
    localparam logic signed [VW:0] NDN_ENTRY =
        (NEG_STEP_W < NEG_PEAK_W) ? NEG_PEAK_W : NEG_STEP_W;
    localparam logic signed [VW:0] NUP_ENTRY =
        ((NEG_PEAK_W + STEP_W) > ZERO_W) ? ZERO_W : (NEG_PEAK_W + STEP_W);

    state_t            state;
    logic [DW-1:0]     cnt;

    logic signed [VW:0] vin_w;
    logic signed [VW:0] up_w;
    logic signed [VW:0] dn_w;
    logic signed [VW:0] p_up_next;
    logic signed [VW:0] p_dn_next;
    logic signed [VW:0] n_dn_next;
    logic signed [VW:0] n_up_next;
    logic [DW-1:0]      cnt_inc;
    logic               more_sweeps;

    // NOTE: every signal driven here gets a value on every path (all are plain
    // continuous expressions), so no latch can be inferred.
    always_comb begin
        vin_w       = {vin[VW-1], vin};
        up_w        = vin_w + STEP_W;
        dn_w        = vin_w - STEP_W;
        p_up_next   = (up_w > PEAK_W)     ? PEAK_W     : up_w;
        p_dn_next   = (dn_w < ZERO_W)     ? ZERO_W     : dn_w;
        n_dn_next   = (dn_w < NEG_PEAK_W) ? NEG_PEAK_W : dn_w;
        n_up_next   = (up_w > ZERO_W)     ? ZERO_W     : up_w;
        cnt_inc     = cnt + 1'b1;
        more_sweeps = ({24'd0, sweep_idx} + 32'd1) < 32'(NSWEEP);
    end

    // NOTE: all state is updated with non-blocking assignments so every
    // register samples the pre-edge values, independent of statement order.
    always_ff @(posedge clk) begin
        if (reset) begin
            state        <= IDLE;
            cnt          <= '0;
            vin          <= '0;
            phase        <= 2'd0;
            sample_valid <= 1'b0;
            busy         <= 1'b0;
            done         <= 1'b0;
            sweep_idx    <= 8'd0;
        end else begin
            case (state)
                IDLE: begin
                    cnt          <= '0;
                    vin          <= '0;
                    phase        <= 2'd0;
                    sample_valid <= 1'b0;
                    busy         <= 1'b0;
                    done         <= 1'b0;
                    sweep_idx    <= 8'd0;
                    // abort beats a simultaneous start.
                    if (start && !abort) begin
                        state        <= RUN_P_UP;
                        vin          <= STEP_W[VW-1:0];
                        busy         <= 1'b1;
                        sample_valid <= SV_FIRST;
                    end
                end

                FINISH: begin
                    state     <= IDLE;
                    done      <= 1'b0;
                    sweep_idx <= 8'd0;
                end

                default: begin
                    if (abort) begin
                        state        <= IDLE;
                        cnt          <= '0;
                        vin          <= '0;
                        phase        <= 2'd0;
                        sample_valid <= 1'b0;
                        busy         <= 1'b0;
                        done         <= 1'b0;
                        sweep_idx    <= 8'd0;
                    end else if (cnt != DWELL_LAST) begin
                        // Still holding the current value.
                        cnt          <= cnt_inc;
                        sample_valid <= (cnt_inc == DWELL_LAST);
                    end else begin
                        // Dwell expired: advance vin, possibly to the next
                        // segment.  A segment ends only after its target
                        // value has been held for a full dwell.
                        cnt          <= '0;
                        sample_valid <= SV_FIRST;
                        case (state)
                            RUN_P_UP: begin
                                if (vin_w == PEAK_W) begin
                                    state <= RUN_P_DN;
                                    phase <= 2'd1;
                                    vin   <= PDN_ENTRY[VW-1:0];
                                end else begin
                                    vin   <= p_up_next[VW-1:0];
                                end
                            end
                            RUN_P_DN: begin
                                if (vin_w == ZERO_W) begin
                                    state <= RUN_N_DN;
                                    phase <= 2'd2;
                                    vin   <= NDN_ENTRY[VW-1:0];
                                end else begin
                                    vin   <= p_dn_next[VW-1:0];
                                end
                            end
                            RUN_N_DN: begin
                                if (vin_w == NEG_PEAK_W) begin
                                    state <= RUN_N_UP;
                                    phase <= 2'd3;
                                    vin   <= NUP_ENTRY[VW-1:0];
                                end else begin
                                    vin   <= n_dn_next[VW-1:0];
                                end
                            end
                            RUN_N_UP: begin
                                if (vin_w == ZERO_W) begin
                                    phase <= 2'd0;
                                    if (more_sweeps) begin
                                        state <= RUN_P_UP;
                                        vin   <= STEP_W[VW-1:0];
                                        if (sweep_idx != 8'hFF) begin
                                            sweep_idx <= sweep_idx + 8'd1;
                                        end
                                    end else begin
                                        // One-cycle completion state.
                                        state        <= FINISH;
                                        vin          <= '0;
                                        busy         <= 1'b0;
                                        done         <= 1'b1;
                                        sample_valid <= 1'b0;
                                    end
                                end else begin
                                    vin   <= n_up_next[VW-1:0];
                                end
                            end
                            default: begin
                                state <= IDLE;
                            end
                        endcase
                    end
                end
            endcase
        end
    end

endmodule

// File: doc/vin_sweep_gen.md
Name: vin_sweep_gen

Overview:
- Upstream stimulus stage for memristor_conductance; drives its signed vin port with a repeatable bipolar triangle sweep: 0 -> +VPEAK -> 0 -> -VPEAK -> 0.
- Replaces hand-written bench sweeps with a synthesizable generator, so PUF characterisation runs identically in simulation and on silicon.
- Provides per-step sample strobes so the downstream G capture logic knows when vin has settled.

Parameters:
- VW, 8, vin width in bits, two's complement.
- VPEAK, 4, sweep amplitude in vin LSBs; must satisfy 1 <= VPEAK <= 2^(VW-1)-1.
- STEP, 1, vin increment per step; must satisfy 1 <= STEP <= VPEAK.
- DWELL, 1, clock cycles each vin value is held; must be >= 1.
- NSWEEP, 1, full triangle periods per start; must be >= 1.

Ports:
- clk  in  1  system clock, rising edge
- reset  in  1  synchronous, active-high; clears all state
- start  in  1  request a run; sampled only in IDLE
- abort  in  1  synchronous run cancel
- vin  out  VW  signed sweep voltage to memristor_conductance.vin
- phase  out  2  0 = rise to +peak, 1 = fall to 0, 2 = fall to -peak, 3 = rise to 0; 0 when idle
- sample_valid  out  1  high on the last dwell cycle of each vin value
- busy  out  1  high while a run is active
- done  out  1  one-cycle pulse on normal completion
- sweep_idx  out  8  index of the current sweep, 0-based; saturates at 255

Behaviour:
- Reset values: vin=0, phase=0, sample_valid=0, busy=0, done=0, sweep_idx=0. State is IDLE and the dwell counter is 0. Reset overrides start and abort.
- States: IDLE, RUN_P_UP, RUN_P_DN, RUN_N_DN, RUN_N_UP, FINISH. Outputs are registered.
- IDLE: start=1 -> next cycle state=RUN_P_UP, vin=STEP, busy=1, dwell counter=0. start=0 -> remain in IDLE with vin=0.
- Every RUN state holds vin for exactly DWELL cycles. sample_valid=1 on the last of those cycles, i.e. when the dwell counter equals DWELL-1.
- After the dwell expires, vin moves by STEP, clamped at the target value:
  - RUN_P_UP: up toward +VPEAK. Once +VPEAK has been held for its full dwell -> RUN_P_DN with vin=+VPEAK-STEP (clamped to 0).
  - RUN_P_DN: down toward 0. 0 held -> RUN_N_DN with vin=-STEP (clamped to -VPEAK).
  - RUN_N_DN: down toward -VPEAK. -VPEAK held -> RUN_N_UP with vin=-VPEAK+STEP (clamped to 0).
  - RUN_N_UP: up toward 0. 0 held:
    - sweep_idx+1 < NSWEEP -> RUN_P_UP, vin=STEP, sweep_idx increments.
    - otherwise -> FINISH.
- Clamping: when STEP does not divide VPEAK, the final step lands exactly on the peak or zero, never overshoots. All arithmetic is done in VW+1 bits, then truncated.
- Values per sweep: 4*ceil(VPEAK/STEP). Cycles per sweep: that count times DWELL.
- FINISH lasts one cycle: done=1, busy=0, vin=0, phase=0. Next state is IDLE; sweep_idx returns to 0 on entry to IDLE.
- phase reflects the current RUN state. It changes on the same cycle as the first vin value of the new segment.
- start while busy or in FINISH: ignored, no queuing.
- abort=1 in any RUN state -> next cycle IDLE, vin=0, busy=0, sample_valid=0, done stays 0. abort in IDLE is a no-op.
- start and abort together in IDLE: abort wins, and the block stays in IDLE.
- Reset asserted mid-run: next cycle all outputs are at reset values, with no done pulse.

Test Plan:
- Defaults, start pulse at cycle 2 -> vin sequence 1,2,3,4,3,2,1,0,-1,-2,-3,-4,-3,-2,-1,0, one value per cycle. sample_valid high on all 16 cycles. phase goes 0x4, 1x4, 2x4, 3x4. done pulses once, 1 cycle after the final 0. busy is high for exactly 16 cycles.
- DWELL=3, VPEAK=4 -> each vin value is held 3 cycles. sample_valid is high only on the 3rd cycle of each. A run lasts 48 busy cycles.
- STEP=3, VPEAK=4 -> vin goes 3,4,1,0,-3,-4,-1,0, so the clamp hits both peaks and both zero crossings. There are 8 sample_valid pulses.
- NSWEEP=2 -> 32 vin values, two identical triangles back to back. sweep_idx is 0 for the first 16 values and 1 for the last 16. A single done pulse follows the second sweep.
- abort asserted on the 6th busy cycle (vin=2, phase=1) -> next cycle vin=0, busy=0, done never asserts. A fresh start afterwards restarts at vin=1.
- Reset asserted mid-run at vin=-3 -> next cycle all outputs are at reset values. start held high during busy has no effect on an in-flight run.
